// File: rtl/ntt_seq_pkg.sv
// Shared encodings for the NTT conf phase sequencer: FSM states, phase modes,
// entry field layout {mode, count, conf} and the idle conf code.
package ntt_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_RUN_FIX  = 2'd1;
  localparam state_t ST_RUN_WAIT = 2'd2;

  localparam logic MODE_FIX  = 1'b0;
  localparam logic MODE_WAIT = 1'b1;

  localparam int CONF_OFS  = 0;
  localparam int IDLE_CONF = 0;

  function automatic int cnt_ofs(input int conf_w);
    return CONF_OFS + conf_w;
  endfunction

  function automatic int mode_ofs(input int conf_w, input int cnt_w);
    return cnt_ofs(conf_w) + cnt_w;
  endfunction

endpackage

// File: rtl/ntt_seq_table.sv
// Phase table: DEPTH x ENTRY_W register file, lockable synchronous write,
// asynchronous read, cleared by synchronous reset.
module ntt_seq_table
  import ntt_seq_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int ENTRY_W = 21
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_lock,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [ENTRY_W-1:0] o_rdata
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && !i_lock) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ntt_conf_sequencer.sv
// Table-driven conf sequencer for the NTT top_stage: each phase holds a conf
// code for a fixed dwell or until done_flag, with an optional timeout.
//
// state       | meaning
// ST_IDLE     | conf=0, not busy; a pending start loads entry 0 next cycle
// ST_RUN_FIX  | holding conf for the entry's count cycles (0 acts as 1)
// ST_RUN_WAIT | holding conf until done_flag != 0 or the count times out
module ntt_conf_sequencer
  import ntt_seq_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int CONF_W  = 4,
  parameter int CNT_W   = 16,
  parameter int ENTRY_W = CONF_W + CNT_W + 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cfg_we,
  input  logic [AW-1:0]      i_cfg_addr,
  input  logic [ENTRY_W-1:0] i_cfg_wdata,
  input  logic [AW:0]        i_seq_len,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [1:0]         i_done_flag,
  output logic [CONF_W-1:0]  o_conf,
  output logic [AW-1:0]      o_phase_idx,
  output logic               o_busy,
  output logic               o_seq_done,
  output logic               o_timeout_err
);

  localparam int CNT_OFS  = cnt_ofs(CONF_W);
  localparam int MODE_OFS = mode_ofs(CONF_W, CNT_W);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [CONF_W-1:0] CONF_IDLE = CONF_W'(IDLE_CONF);

  state_t             r_state;
  logic               r_start_pend;
  logic               r_done_pend;
  logic [AW:0]        r_len;
  logic [AW-1:0]      r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_count;
  logic [CONF_W-1:0]  r_conf;
  logic               r_busy;
  logic               r_seq_done;
  logic               r_timeout_err;

  logic [AW-1:0]      w_raddr;
  logic [ENTRY_W-1:0] w_rdata;
  logic [CONF_W-1:0]  w_ent_conf;
  logic [CNT_W-1:0]   w_ent_cnt;
  logic               w_ent_mode;
  logic [AW:0]        w_len_clamp;
  logic               w_last;
  logic               w_cnt_hit;
  logic               w_running;
  logic               w_done_seen;
  logic               w_tmo;
  logic               w_adv;

  // The only entry ever fetched is the next one to be loaded.
  assign w_raddr = r_start_pend ? '0 : r_idx + AW'(1);

  ntt_seq_table #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .ENTRY_W (ENTRY_W)
  ) u_table (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_lock  (r_busy),
    .i_we    (i_cfg_we),
    .i_waddr (i_cfg_addr),
    .i_wdata (i_cfg_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_ent_conf  = w_rdata[CONF_OFS +: CONF_W];
  assign w_ent_cnt   = w_rdata[CNT_OFS +: CNT_W];
  assign w_ent_mode  = w_rdata[MODE_OFS];
  assign w_len_clamp = (i_seq_len > LEN_MAX) ? LEN_MAX : i_seq_len;

  assign w_last      = ({1'b0, r_idx} == (r_len - (AW+1)'(1)));
  assign w_cnt_hit   = (r_cnt == r_count);
  assign w_running   = (r_state == ST_RUN_WAIT) && !r_done_pend;
  assign w_done_seen = w_running && (i_done_flag != 2'b00);
  assign w_tmo       = w_running && (i_done_flag == 2'b00) && (r_count != '0) && w_cnt_hit;
  assign w_adv       = ((r_state == ST_RUN_FIX) && ((r_count == '0) || w_cnt_hit)) ||
                       ((r_state == ST_RUN_WAIT) && r_done_pend);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_start_pend  <= 1'b0;
      r_done_pend   <= 1'b0;
      r_len         <= '0;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_count       <= '0;
      r_conf        <= CONF_IDLE;
      r_busy        <= 1'b0;
      r_seq_done    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_seq_done <= 1'b0;
      if ((r_state != ST_IDLE) && i_abort) begin
        r_state     <= ST_IDLE;
        r_done_pend <= 1'b0;
        r_idx       <= '0;
        r_conf      <= CONF_IDLE;
        r_busy      <= 1'b0;
      end else if (r_state == ST_IDLE) begin
        if (r_start_pend) begin
          r_start_pend <= 1'b0;
          if (r_len == '0) begin
            r_seq_done <= 1'b1;
          end else begin
            r_state     <= (w_ent_mode == MODE_WAIT) ? ST_RUN_WAIT : ST_RUN_FIX;
            r_conf      <= w_ent_conf;
            r_count     <= w_ent_cnt;
            r_cnt       <= CNT_W'(1);
            r_done_pend <= 1'b0;
            r_busy      <= 1'b1;
          end
        end else if (i_start) begin
          r_start_pend  <= 1'b1;
          r_len         <= w_len_clamp;
          r_idx         <= '0;
          r_timeout_err <= 1'b0;
        end
      end else if (w_tmo) begin
        r_state       <= ST_IDLE;
        r_idx         <= '0;
        r_conf        <= CONF_IDLE;
        r_busy        <= 1'b0;
        r_timeout_err <= 1'b1;
      end else if (w_done_seen) begin
        // Handshake completion costs one cycle before the next conf appears.
        r_done_pend <= 1'b1;
      end else if (w_adv) begin
        r_done_pend <= 1'b0;
        if (w_last) begin
          r_state    <= ST_IDLE;
          r_idx      <= '0;
          r_conf     <= CONF_IDLE;
          r_busy     <= 1'b0;
          r_seq_done <= 1'b1;
        end else begin
          r_state <= (w_ent_mode == MODE_WAIT) ? ST_RUN_WAIT : ST_RUN_FIX;
          r_idx   <= r_idx + AW'(1);
          r_conf  <= w_ent_conf;
          r_count <= w_ent_cnt;
          r_cnt   <= CNT_W'(1);
        end
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_conf        = r_conf;
  assign o_phase_idx   = r_idx;
  assign o_busy        = r_busy;
  assign o_seq_done    = r_seq_done;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ntt_conf_sequencer.sv
// Scoreboard bench for ntt_conf_sequencer: stimulus queues timestamped output
// events, a negedge monitor pops one whenever any output changes.
module tb_ntt_conf_sequencer;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int CONF_W  = 4;
  localparam int CNT_W   = 16;
  localparam int ENTRY_W = CONF_W + CNT_W + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_we = 1'b0;
  logic [AW-1:0]      cfg_addr = '0;
  logic [ENTRY_W-1:0] cfg_wdata = '0;
  logic [AW:0]        seq_len = '0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [1:0]         done_flag = 2'b00;
  logic [CONF_W-1:0]  conf;
  logic [AW-1:0]      phase_idx;
  logic               busy;
  logic               seq_done;
  logic               timeout_err;

  ntt_conf_sequencer #(
    .DEPTH(DEPTH), .AW(AW), .CONF_W(CONF_W), .CNT_W(CNT_W), .ENTRY_W(ENTRY_W)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cfg_we      (cfg_we),
    .i_cfg_addr    (cfg_addr),
    .i_cfg_wdata   (cfg_wdata),
    .i_seq_len     (seq_len),
    .i_start       (start),
    .i_abort       (abort),
    .i_done_flag   (done_flag),
    .o_conf        (conf),
    .o_phase_idx   (phase_idx),
    .o_busy        (busy),
    .o_seq_done    (seq_done),
    .o_timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         c;
    logic [3:0] cf;
    logic [3:0] ix;
    logic       b;
    logic       d;
    logic       t;
  } ev_t;

  ev_t exp_q[$];
  ev_t got, want;
  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;
  logic [3:0] p_conf, p_idx;
  logic p_busy, p_terr;

  always @(negedge clk) begin
    if (mon_en) begin
      if (conf != p_conf || phase_idx != p_idx || busy != p_busy ||
          timeout_err != p_terr || seq_done) begin
        got = '{cyc, conf, phase_idx, busy, seq_done, timeout_err};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event got cyc=%0d conf=%0d idx=%0d busy=%0b done=%0b terr=%0b want none",
                   got.c, got.cf, got.ix, got.b, got.d, got.t);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            bad++;
            $display("FAIL event got cyc=%0d conf=%0d idx=%0d busy=%0b done=%0b terr=%0b want cyc=%0d conf=%0d idx=%0d busy=%0b done=%0b terr=%0b",
                     got.c, got.cf, got.ix, got.b, got.d, got.t,
                     want.c, want.cf, want.ix, want.b, want.d, want.t);
          end
        end
      end
      p_conf = conf;
      p_idx  = phase_idx;
      p_busy = busy;
      p_terr = timeout_err;
    end
  end

  task automatic expect_ev(input int c, input logic [3:0] cf, input logic [3:0] ix,
                           input logic b, input logic d, input logic t);
    exp_q.push_back('{c, cf, ix, b, d, t});
  endtask

  task automatic write_entry(input int a, input logic mode, input int cnt, input int cf);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(a);
    cfg_wdata = {mode, CNT_W'(cnt), CONF_W'(cf)};
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    start   = 1'b1;
    seq_len = (AW+1)'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input string nm, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_pending got=%0d want=0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int n, s, cnt, cf;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++;
    if ({conf, phase_idx, busy, seq_done, timeout_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%0h want=0", {conf, phase_idx, busy, seq_done, timeout_err});
    end
    p_conf = conf; p_idx = phase_idx; p_busy = busy; p_terr = timeout_err;
    mon_en = 1'b1;

    // Test 1: fix/fix/wait, done after 500 cycles of phase 2; write while busy dropped.
    write_entry(0, 1'b0, 128, 1);
    write_entry(1, 1'b0, 44, 3);
    write_entry(2, 1'b1, 1000, 2);
    n = cyc;
    expect_ev(n + 2,   1, 0, 1, 0, 0);
    expect_ev(n + 130, 3, 1, 1, 0, 0);
    expect_ev(n + 174, 2, 2, 1, 0, 0);
    expect_ev(n + 675, 0, 0, 0, 1, 0);
    pulse_start(3);
    wait_until(n + 20);
    write_entry(1, 1'b0, 44, 9);
    wait_until(n + 673);
    done_flag = 2'b01;
    @(negedge clk);
    done_flag = 2'b00;
    drain("handshake", 100);

    // Test 2: done never arrives, timeout after 1000 cycles of phase 2.
    n = cyc;
    expect_ev(n + 2,    1, 0, 1, 0, 0);
    expect_ev(n + 130,  3, 1, 1, 0, 0);
    expect_ev(n + 174,  2, 2, 1, 0, 0);
    expect_ev(n + 1174, 0, 0, 0, 0, 1);
    pulse_start(3);
    drain("timeout", 1300);

    // Test 3: next start clears timeout_err; abort in phase 1.
    n = cyc;
    expect_ev(n + 1,   0, 0, 0, 0, 0);
    expect_ev(n + 2,   1, 0, 1, 0, 0);
    expect_ev(n + 130, 3, 1, 1, 0, 0);
    expect_ev(n + 141, 0, 0, 0, 0, 0);
    pulse_start(3);
    wait_until(n + 140);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain("abort", 100);

    // Abort while idle must not produce any output change.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // Test 4: zero-length sequence.
    n = cyc;
    expect_ev(n + 2, 0, 0, 0, 1, 0);
    pulse_start(0);
    drain("len0", 20);

    // Test 5: seq_len=31 clamps to 16 phases; entry 3 has count 0; start held high.
    for (int i = 0; i < DEPTH; i++) begin
      write_entry(i, 1'b0, (i == 3) ? 0 : (i % 4) + 1, i ^ 5);
    end
    n = cyc;
    s = n + 2;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = (i == 3) ? 0 : (i % 4) + 1;
      cf  = i ^ 5;
      expect_ev(s, 4'(cf), 4'(i), 1, 0, 0);
      s += (cnt == 0) ? 1 : cnt;
    end
    expect_ev(s, 0, 0, 0, 1, 0);
    start   = 1'b1;
    seq_len = 5'd31;
    repeat (10) @(negedge clk);
    start = 1'b0;
    drain("clamp16", 100);

    // Test 6: reset mid-run clears outputs and table.
    write_entry(0, 1'b0, 1000, 7);
    write_entry(1, 1'b0, 1000, 8);
    n = cyc;
    expect_ev(n + 2,  7, 0, 1, 0, 0);
    expect_ev(n + 51, 0, 0, 0, 0, 0);
    pulse_start(2);
    wait_until(n + 50);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drain("rst_mid", 20);

    n = cyc;
    expect_ev(n + 2, 0, 0, 1, 0, 0);
    expect_ev(n + 3, 0, 1, 1, 0, 0);
    expect_ev(n + 4, 0, 0, 0, 1, 0);
    pulse_start(2);
    drain("table_zero", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ntt_conf_sequencer.md
# ntt_conf_sequencer

Programmable phase sequencer that drives the `conf` code of the mixed-radix NTT `top_stage`. It replaces fixed-delay conf stepping with a loadable table of phases. Each phase either holds a conf code for a programmed number of cycles or holds it until `top_stage` raises `done_flag`, with a timeout. It sits between the host/control logic and `top_stage`, one instance per NTT datapath.

## Interface
Parameters:
- `DEPTH`, 16: number of phase-table entries (power of two).
- `AW`, 4: table address width, equal to log2(`DEPTH`).
- `CONF_W`, 4: width of the conf code.
- `CNT_W`, 16: width of the dwell/timeout count.
- `ENTRY_W`, `CONF_W+CNT_W+1`: entry layout is {mode[1], count[CNT_W], conf[CONF_W]}.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  table write strobe.
- `cfg_addr`  in  AW  table write address.
- `cfg_wdata`  in  ENTRY_W  table write data.
- `seq_len`  in  AW+1  number of phases to run; sampled on accepted `start`.
- `start`  in  1  begin the sequence.
- `abort`  in  1  cancel the running sequence.
- `done_flag`  in  2  phase-complete status from `top_stage`.
- `conf`  out  CONF_W  conf code to `top_stage`.
- `phase_idx`  out  AW  index of the current phase.
- `busy`  out  1  sequence running.
- `seq_done`  out  1  one-cycle pulse when the sequence completes normally.
- `timeout_err`  out  1  sticky flag; cleared by the next accepted `start` or by `rst`.

## Operation
- The table is a register array with asynchronous read. `cfg_we` writes at a clock edge and is honoured only while `busy`=0; writes while busy are dropped.
- States:
  - IDLE: `conf`=0 and `busy`=0.
  - RUN_FIX: mode 0.
  - RUN_WAIT: mode 1.
- `start` in IDLE:
  - `seq_len` is clamped to `DEPTH` and latched.
  - `phase_idx`=0 and `timeout_err` is cleared.
  - If the length is 0, `seq_done` pulses on the next cycle and the block stays in IDLE.
  - Otherwise the block enters RUN_FIX or RUN_WAIT according to entry 0's mode.
  - `start` while busy is ignored.
- Mode 0, fixed dwell: `conf` holds the entry's conf for exactly `count` cycles. A `count` of 0 is treated as 1. `done_flag` is ignored.
- Mode 1, handshake: `conf` holds until `done_flag`≠2'b00 is sampled.
  - If `count`≠0 and `count` cycles elapse with no done, `timeout_err` is set, `conf` goes to 0, `busy` goes to 0, and there is no `seq_done`.
  - A `count` of 0 means no timeout.
  - If done and timeout fall on the same cycle, done wins.
- Phase end:
  - If `phase_idx`<len-1, the index increments and the next entry's conf is driven with no gap cycle.
  - If it is the last phase, `conf` goes to 0, `busy` goes to 0, and `seq_done` pulses.
- `abort` overrides everything except `rst`. On the next cycle the block is in IDLE with `conf`=0, and there is no `seq_done` and no error. `abort` in IDLE has no effect.
- The per-phase counter is CNT_W bits, counts up from 1, and compares against `count`. It never wraps.

## Timing
- Reset values:
  - `conf`=0, `phase_idx`=0, `busy`=0, `seq_done`=0, `timeout_err`=0.
  - State is IDLE.
  - Table contents are zeroed.
- `rst` during a run returns the block to IDLE on the next edge. It overrides `start`, `abort` and `cfg_we`.
- `start` sampled at edge E: `busy`=1, `conf`=entry0.conf and `phase_idx`=0 are visible after edge E+1.
- `done_flag` sampled high at edge D: the next phase's conf (or `conf`=0 and `seq_done`) is visible after edge D+1. There is one cycle of latency.
- The mode-1 timeout fires at the edge ending cycle `count`. `timeout_err` is visible immediately after that edge.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Shared package/header `ntt_seq_pkg` holds:
  - the state encoding (IDLE, RUN_FIX, RUN_WAIT);
  - mode constants MODE_FIX=0 and MODE_WAIT=1;
  - entry field offsets;
  - IDLE_CONF=0.
- One sub-module, `ntt_seq_table`: a DEPTH×ENTRY_W register file with a synchronous write port (gated by a lock input), an async read port, and synchronous reset.
- The FSM, phase counter and output registers live in the top.

## Test plan
- Table {1,fix,128},{3,fix,44},{2,wait,1000}, `seq_len`=3, `done_flag`=01 asserted 500 cycles into phase 2:
  - expect `conf`=1 for 128 cycles, then 3 for 44 cycles, then 2 until done+1;
  - then `conf`=0 and a single `seq_done` pulse; `timeout_err`=0.
- Same table with `done_flag` never asserted:
  - `timeout_err`=1 exactly 1000 cycles after phase 2 begins; `conf`=0, `busy`=0, no `seq_done`;
  - the next `start` clears `timeout_err`.
- `abort` during phase 1:
  - one cycle later `conf`=0 and `busy`=0, no `seq_done`, `phase_idx`=0.
- `seq_len`=0:
  - `seq_done` pulses one cycle after `start`, `busy` stays 0.
- `seq_len`=31 with `DEPTH`=16:
  - exactly 16 phases run.
- `cfg_we` to entry 1 while busy:
  - the write is dropped and the original conf is seen in phase 1.
- Mode-0 `count`=0:
  - `conf` is held for 1 cycle.
- `start` held while busy:
  - no restart.
- `rst` mid-run:
  - all outputs and table contents return to 0.
